// File: rtl/cluster_pkg.sv
// Shared types, sizes and cluster-field helpers for the cluster unpacker.
package cluster_pkg;

    localparam int CLUSTER_W       = 14;
    localparam int ADR_W           = 11;
    localparam int CNT_W           = 3;
    localparam int NUM_STRIPS      = 1536;
    localparam int NUM_VFATS       = 24;
    localparam int STRIPS_PER_VFAT = 64;
    localparam int NUM_CLUSTERS    = 8;
    localparam int DEC_PER_CYCLE   = 2;
    localparam int NUM_STEPS       = NUM_CLUSTERS / DEC_PER_CYCLE;

    localparam logic [ADR_W-1:0] NULL_ADR = 11'h7FF;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [ADR_W-1:0] adr;
    } cluster_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

    function automatic logic [ADR_W-1:0] get_adr(input logic [CLUSTER_W-1:0] word);
        cluster_t c;
        c = cluster_t'(word);
        return c.adr;
    endfunction

    function automatic logic [CNT_W-1:0] get_cnt(input logic [CLUSTER_W-1:0] word);
        cluster_t c;
        c = cluster_t'(word);
        return c.cnt;
    endfunction

    function automatic logic is_valid(input logic [CLUSTER_W-1:0] word);
        return (get_adr(word) < 11'd1536);
    endfunction

endpackage

// File: rtl/cluster_mask_expand.sv
// Expands one cluster word into its strip mask over the full S-bit map.
module cluster_mask_expand
    import cluster_pkg::*;
(
    input  logic [CLUSTER_W-1:0]  cluster_in,
    output logic [NUM_STRIPS-1:0] mask_out,
    output logic                  valid_out
);

    logic [7:0]            run_s;
    logic [NUM_STRIPS-1:0] base_s;

    // Run of cnt+1 ones shifted to adr; bits pushed past the top strip fall off.
    always_comb begin
        valid_out = is_valid(cluster_in);
        run_s     = 8'hFF >> (3'd7 - get_cnt(cluster_in));
        base_s    = {{(NUM_STRIPS-8){1'b0}}, run_s};
        if (valid_out) begin
            mask_out = base_s << get_adr(cluster_in);
        end else begin
            mask_out = {NUM_STRIPS{1'b0}};
        end
    end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the 1536-strip S-bit map from 8 cluster words, two clusters per clock.
// Optional overlap detection is built when CLUSTER_UNPACKER_OVERLAP_CHECK_EN is defined.
module cluster_unpacker
    import cluster_pkg::*;
(
    input  logic                              clock4x,
    input  logic                              global_reset,
    input  logic [NUM_CLUSTERS*CLUSTER_W-1:0] clusters_in,
    input  logic                              clusters_valid,
    output logic [NUM_STRIPS-1:0]             sbits_out,
    output logic                              sbits_valid,
    output logic [3:0]                        cluster_count,
    output logic                              overflow,
    output logic                              overlap_err
);

    state_t                                   state_q, state_d;
    logic [1:0]                               step_q, step_d;
    logic [NUM_CLUSTERS-1:0][CLUSTER_W-1:0]   hold_q, hold_d;
    logic [NUM_STRIPS-1:0]                    work_q, work_d;
    logic [3:0]                               count_q, count_d;
    logic [NUM_STRIPS-1:0]                    sbits_q, sbits_d;
    logic                                     valid_q, valid_d;
    logic [3:0]                               ccount_q, ccount_d;
    logic                                     overflow_q, overflow_d;

    logic [DEC_PER_CYCLE-1:0][NUM_STRIPS-1:0] mask_s;
    logic [DEC_PER_CYCLE-1:0]                 mvalid_s;
    logic [NUM_STRIPS-1:0]                    next_work_s;
    logic [3:0]                               next_count_s;

    genvar gi;
    generate
        for (gi = 0; gi < DEC_PER_CYCLE; gi++) begin : g_dec
            cluster_mask_expand u_expand (
                .cluster_in (hold_q[{step_q, 1'(gi)}]),
                .mask_out   (mask_s[gi]),
                .valid_out  (mvalid_s[gi])
            );
        end
    endgenerate

`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    logic overlap_q, overlap_d;
    logic hit_s;

    // A pair overlaps if either mask hits the work map or the two masks collide.
    always_comb begin
        hit_s = |(((mask_s[0] | mask_s[1]) & work_q) | (mask_s[0] & mask_s[1]));
        if ((state_q == ST_DECODE) && hit_s) begin
            overlap_d = 1'b1;
        end else begin
            overlap_d = overlap_q;
        end
    end

    // Sticky overlap flag.
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            overlap_q <= 1'b0;
        end else begin
            overlap_q <= overlap_d;
        end
    end

    assign overlap_err = overlap_q;
`else
    assign overlap_err = 1'b0;
`endif

    // Next-state logic for the decode FSM, accumulators and output registers.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        hold_d       = hold_q;
        work_d       = work_q;
        count_d      = count_q;
        sbits_d      = sbits_q;
        valid_d      = 1'b0;
        ccount_d     = ccount_q;
        overflow_d   = overflow_q;
        next_work_s  = work_q | mask_s[0] | mask_s[1];
        next_count_s = count_q + {3'b000, mvalid_s[0]} + {3'b000, mvalid_s[1]};
        case (state_q)
            ST_IDLE: begin
                if (clusters_valid) begin
                    hold_d  = clusters_in;
                    work_d  = {NUM_STRIPS{1'b0}};
                    count_d = 4'd0;
                    step_d  = 2'd0;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (step_q == 2'd3) begin
                    sbits_d  = next_work_s;
                    ccount_d = next_count_s;
                    valid_d  = 1'b1;
                    // Accepting here keeps back-to-back BX at one set per four clocks.
                    if (clusters_valid) begin
                        hold_d  = clusters_in;
                        work_d  = {NUM_STRIPS{1'b0}};
                        count_d = 4'd0;
                        step_d  = 2'd0;
                        state_d = ST_DECODE;
                    end else begin
                        work_d  = next_work_s;
                        count_d = next_count_s;
                        state_d = ST_IDLE;
                    end
                end else begin
                    work_d  = next_work_s;
                    count_d = next_count_s;
                    step_d  = step_q + 2'd1;
                    if (clusters_valid) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 2'd0;
            hold_q     <= {(NUM_CLUSTERS*CLUSTER_W){1'b0}};
            work_q     <= {NUM_STRIPS{1'b0}};
            count_q    <= 4'd0;
            sbits_q    <= {NUM_STRIPS{1'b0}};
            valid_q    <= 1'b0;
            ccount_q   <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            work_q     <= work_d;
            count_q    <= count_d;
            sbits_q    <= sbits_d;
            valid_q    <= valid_d;
            ccount_q   <= ccount_d;
            overflow_q <= overflow_d;
        end
    end

    assign sbits_out     = sbits_q;
    assign sbits_valid   = valid_q;
    assign cluster_count = ccount_q;
    assign overflow      = overflow_q;

endmodule
